// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared types and helpers for the carry-pipelined adder/subtractor.
//   op_e      : operation select (OP_ADD / OP_SUB), matches sub_i encoding
//   chunk_w   : bits added per pipeline slice (WIDTH / STAGES)
//   stages_ok : elaboration-time legality check of the WIDTH/STAGES pair
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Guarded against STAGES=0 so elaboration reaches the legality check
   // instead of dying on a divide by zero.
   function automatic int chunk_w(input int width, input int stages);
      return (stages > 0) ? (width / stages) : 1;
   endfunction

   function automatic bit stages_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// -----------------------------------------------------------------------------
// pipe_adder_if
// Handshake and data bundle of pipe_adder.
//   valid_i/ready_o : operand transfer   (a_i, b_i, carry_i, sub_i)
//   valid_o/ready_i : result transfer    (sum_o, carry_o[, ovf_o])
// Signal names keep the adder's point of view: *_i are driven by the
// upstream/downstream master, *_o by the adder.
// Optional macro PIPE_ADDER_OVF_EN adds ovf_o (signed overflow).
// Modports: slave = adder side, master = environment side.
// -----------------------------------------------------------------------------
interface pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             carry_i;
   logic             sub_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] sum_o;
   logic             carry_o;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf_o;

   modport slave (
      input  valid_i, a_i, b_i, carry_i, sub_i, ready_i,
      output ready_o, valid_o, sum_o, carry_o, ovf_o
   );
   modport master (
      output valid_i, a_i, b_i, carry_i, sub_i, ready_i,
      input  ready_o, valid_o, sum_o, carry_o, ovf_o
   );
`else
   modport slave (
      input  valid_i, a_i, b_i, carry_i, sub_i, ready_i,
      output ready_o, valid_o, sum_o, carry_o
   );
   modport master (
      output valid_i, a_i, b_i, carry_i, sub_i, ready_i,
      input  ready_o, valid_o, sum_o, carry_o
   );
`endif
endinterface

// File: rtl/pipe_adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Combinational CHUNK-bit adder used once per pipeline stage.
//   a_i, b_i    : slice operands (b_i already inverted for subtract)
//   carry_i     : carry into the slice LSB
//   sum_o       : slice sum
//   carry_o     : carry out of the slice MSB
//   msb_carry_o : carry into the slice MSB (only with PIPE_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module adder_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             carry_i,
   output logic [CHUNK-1:0] sum_o,
`ifdef PIPE_ADDER_OVF_EN
   output logic             msb_carry_o,
`endif
   output logic             carry_o
);
   logic [CHUNK:0] w_full;

   assign w_full  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
   assign sum_o   = w_full[CHUNK-1:0];
   assign carry_o = w_full[CHUNK];
`ifdef PIPE_ADDER_OVF_EN
   // Carry that entered the MSB is recovered from its sum bit: s = a ^ b ^ c.
   assign msb_carry_o = w_full[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
`endif
endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// WIDTH-bit adder/subtractor split into STAGES carry-pipelined slices of
// CHUNK = WIDTH/STAGES bits. Slice k is added in stage k using the carry
// registered by stage k-1; lower result slices ride along unchanged so the
// full sum is aligned at the last stage. Latency STAGES, throughput 1/cycle.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset (clears all pipeline state)
//   bus   : pipe_adder_if.slave (valid/ready in, operands, valid/ready out,
//           sum_o, carry_o, and ovf_o when PIPE_ADDER_OVF_EN is defined)
// Optional macro PIPE_ADDER_OVF_EN: adds registered signed-overflow ovf_o.
// -----------------------------------------------------------------------------
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   pipe_adder_if.slave  bus
);
   localparam int CHUNK = chunk_w(WIDTH, STAGES);

   generate
      if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
         $error("pipe_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
      end
   endgenerate

   op_e              w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic             w_adv;

   // Per-slice adder connections
   logic [CHUNK-1:0] w_sa [STAGES];
   logic [CHUNK-1:0] w_sb [STAGES];
   logic [CHUNK-1:0] w_ss [STAGES];
   logic             w_sc [STAGES];
   logic             w_co [STAGES];
`ifdef PIPE_ADDER_OVF_EN
   logic             w_msb [STAGES];
   logic             r_ovf;
`endif

   // Pipeline registers, index = stage
   logic             r_vld   [STAGES];
   logic             r_carry [STAGES];
   logic [WIDTH-1:0] r_a     [STAGES];
   logic [WIDTH-1:0] r_b     [STAGES];
   logic [WIDTH-1:0] r_sum   [STAGES];

   // Subtract is A + ~B + 1; carry_i is ignored in that case.
   assign w_op    = op_e'(bus.sub_i);
   assign w_b_eff = (w_op == OP_SUB) ? ~bus.b_i : bus.b_i;
   assign w_cin   = (w_op == OP_SUB) ? 1'b1 : bus.carry_i;

   // Whole pipeline moves in lockstep; it only freezes when the output
   // holds a result that downstream refuses.
   assign w_adv       = !r_vld[STAGES-1] || bus.ready_i;
   assign bus.ready_o = w_adv;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_slice
         if (k == 0) begin : g_first
            assign w_sa[k] = bus.a_i[CHUNK-1:0];
            assign w_sb[k] = w_b_eff[CHUNK-1:0];
            assign w_sc[k] = w_cin;
         end else begin : g_next
            assign w_sa[k] = r_a[k-1][k*CHUNK +: CHUNK];
            assign w_sb[k] = r_b[k-1][k*CHUNK +: CHUNK];
            assign w_sc[k] = r_carry[k-1];
         end

         adder_slice #(
            .CHUNK (CHUNK)
         ) u_slice (
            .a_i         (w_sa[k]),
            .b_i         (w_sb[k]),
            .carry_i     (w_sc[k]),
            .sum_o       (w_ss[k]),
`ifdef PIPE_ADDER_OVF_EN
            .msb_carry_o (w_msb[k]),
`endif
            .carry_o     (w_co[k])
         );
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            r_vld[i]   <= 1'b0;
            r_carry[i] <= 1'b0;
            r_a[i]     <= '0;
            r_b[i]     <= '0;
            r_sum[i]   <= '0;
         end
`ifdef PIPE_ADDER_OVF_EN
         r_ovf <= 1'b0;
`endif
      end else if (w_adv) begin
         // Stage 0: capture operands (B pre-inverted) and add slice 0.
         // Without an input transfer a bubble enters (ready_o is 1 here).
         r_vld[0]              <= bus.valid_i;
         r_a[0]                <= bus.a_i;
         r_b[0]                <= w_b_eff;
         r_carry[0]            <= w_co[0];
         r_sum[0]              <= '0;
         r_sum[0][CHUNK-1:0]   <= w_ss[0];
         // Stage i: add slice i with the carry from stage i-1, pass the
         // lower slices through unchanged.
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i]                  <= r_vld[i-1];
            r_a[i]                    <= r_a[i-1];
            r_b[i]                    <= r_b[i-1];
            r_carry[i]                <= w_co[i];
            r_sum[i]                  <= r_sum[i-1];
            r_sum[i][i*CHUNK +: CHUNK] <= w_ss[i];
         end
`ifdef PIPE_ADDER_OVF_EN
         // Signed overflow: carry into the MSB differs from carry out.
         r_ovf <= w_msb[STAGES-1] ^ w_co[STAGES-1];
`endif
      end
   end

   assign bus.valid_o = r_vld[STAGES-1];
   assign bus.sum_o   = r_sum[STAGES-1];
   assign bus.carry_o = r_carry[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
   assign bus.ovf_o   = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Scoreboard bench for pipe_adder (WIDTH=32, STAGES=4). Expected results are
// computed by a behavioural model when an operand transfer happens and are
// compared when a result transfer happens.
// Define PIPE_ADDER_OVF_EN to also check ovf_o.
// -----------------------------------------------------------------------------
module tb_pipe_adder;
   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             c;
      logic             ovf;
      int               due;
      bit               timed;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_err;
   bit   lat_on;
   exp_t sb_q[$];

   pipe_adder_if #(.WIDTH(WIDTH)) bus ();

   pipe_adder #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c, input logic s);
      exp_t             e;
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   t;
      bb    = s ? ~b : b;
      t     = {1'b0, a} + {1'b0, bb} + (s ? 33'd1 : {32'd0, c});
      e.sum = t[WIDTH-1:0];
      e.c   = t[WIDTH];
      e.ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
      e.due = 0;
      e.timed = 1'b0;
      return e;
   endfunction

   // One clock cycle: drive inputs at the falling edge, then judge both
   // transfers that the next rising edge will perform.
   task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s, input logic rdy);
      exp_t e;
      @(negedge clk);
      bus.valid_i = v;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.carry_i = c;
      bus.sub_i   = s;
      bus.ready_i = rdy;
      #1;
      if (bus.valid_o && bus.ready_i) begin
         if (sb_q.size() == 0) begin
            chk("spurious_out", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sum", {32'd0, bus.sum_o}, {32'd0, e.sum});
            chk("carry", {63'd0, bus.carry_o}, {63'd0, e.c});
`ifdef PIPE_ADDER_OVF_EN
            chk("ovf", {63'd0, bus.ovf_o}, {63'd0, e.ovf});
`endif
            if (e.timed) chk("latency", 64'(cyc), 64'(e.due));
         end
      end
      if (bus.valid_i && bus.ready_o) begin
         e       = model(a, b, c, s);
         e.due   = cyc + STAGES;
         e.timed = lat_on;
         sb_q.push_back(e);
      end
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb_q.size() > 0 && budget < 20) begin
         idle(1'b1);
         budget++;
      end
      chk("drain_left", 64'(sb_q.size()), 64'd0);
      // Pipeline must stay quiet once everything is out.
      repeat (3) idle(1'b1);
   endtask

   initial begin
      cyc    = 0;
      n_chk  = 0;
      n_err  = 0;
      lat_on = 1'b1;
      rst    = 1'b1;
      bus.valid_i = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.carry_i = 1'b0;
      bus.sub_i   = 1'b0;
      bus.ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid_o", {63'd0, bus.valid_o}, 64'd0);
      chk("rst_sum_o",   {32'd0, bus.sum_o},   64'd0);
      chk("rst_carry_o", {63'd0, bus.carry_o}, 64'd0);
      chk("rst_ready_o", {63'd0, bus.ready_o}, 64'd1);

      // Single add with explicit latency observation.
      step(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i < STAGES; i++) begin
         idle(1'b1);
         chk("early_valid", {63'd0, bus.valid_o}, 64'd0);
      end
      idle(1'b1);
      chk("first_sum_literal", {32'd0, bus.sum_o}, 64'h100);
      drain();

      // Cross-slice ripple, subtracts, signed overflow, carry_i with add/sub.
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'd5,         32'd7,         1'b0, 1'b1, 1'b1);
      step(1'b1, 32'd7,         32'd5,         1'b0, 1'b1, 1'b1);
      step(1'b1, 32'h8000_0000, 32'd1,         1'b0, 1'b1, 1'b1);
      step(1'b1, 32'h7FFF_FFFF, 32'd0,         1'b1, 1'b0, 1'b1);
      step(1'b1, 32'd9,         32'd4,         1'b1, 1'b1, 1'b1);
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
      drain();

      // Back-to-back random stream.
      for (int i = 0; i < 10; i++)
         step(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
      drain();

      // Backpressure: fill with ready_i low, stall, then stream while full.
      lat_on = 1'b0;
      for (int i = 0; i < STAGES; i++)
         step(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
         chk("stall_ready_o", {63'd0, bus.ready_o}, 64'd0);
         chk("stall_valid_o", {63'd0, bus.valid_o}, 64'd1);
         chk("stall_sum_o",   {32'd0, bus.sum_o},   {32'd0, sb_q[0].sum});
         chk("stall_depth",   64'(sb_q.size()),     64'(STAGES));
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
         chk("full_ready_o", {63'd0, bus.ready_o}, 64'd1);
      end
      drain();
      lat_on = 1'b1;

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++)
         step(1'b1, $urandom | 32'h1, $urandom, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      bus.valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_valid_o", {63'd0, bus.valid_o}, 64'd0);
      chk("arst_sum_o",   {32'd0, bus.sum_o},   64'd0);
      chk("arst_carry_o", {63'd0, bus.carry_o}, 64'd0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < STAGES + 2; i++) begin
         idle(1'b1);
         chk("post_rst_quiet", {63'd0, bus.valid_o}, 64'd0);
      end
      step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised successor of the 4-bit ripple full adder: a WIDTH-bit adder/subtractor split into STAGES carry-pipelined slices.
- Each slice adds CHUNK = WIDTH/STAGES bits per cycle; its carry is registered into the next stage.
- Valid/ready handshake on input and output, with a stall path.
- Sits in datapaths needing wide add/sub at high clock rate.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 4, pipeline depth; must divide WIDTH exactly, 1 <= STAGES <= WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept an input this cycle.
- a_i  in  WIDTH  operand A, unsigned or two's complement.
- b_i  in  WIDTH  operand B.
- carry_i  in  1  carry-in; ignored when sub_i=1.
- sub_i  in  1  0: A+B+carry_i; 1: A-B, computed as A + ~B + 1.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- sum_o  out  WIDTH  result.
- carry_o  out  1  carry-out of the MSB; for subtract, 1 means no borrow.

Behaviour:
- Reset, asynchronous on rst_i high: all stage valid bits, carry registers, and operand/result registers clear to 0. valid_o=0, sum_o=0, carry_o=0. ready_o=1 once reset is released. An in-flight operation is discarded with no output.
- Global advance: adv = !valid_o || ready_i. ready_o = adv, combinational, no dependency on valid_i.
- Input transfer: on valid_i && ready_o.
- Output transfer: on valid_o && ready_i.
- When adv=1, every stage shifts forward one step. A bubble (valid=0) enters when no input transfer occurs.
- When adv=0, all pipeline registers hold, and sum_o, carry_o and valid_o stay stable.
- Stage 0 on capture:
  - Computes slice 0 as a[CHUNK-1:0] + b'[CHUNK-1:0] + cin, where b' = sub ? ~b : b and cin = sub ? 1 : carry_i.
  - Stores the remaining upper operand slices, already inverted for subtract, plus the slice carry.
- Stage k: adds slice k using the registered carry from stage k-1. Lower result slices pass through registers unchanged (skew-aligned).
- Latency: exactly STAGES cycles from input transfer to valid_o, with no stalls. Throughput: 1 result per cycle.
- STAGES=1 degenerates to a single registered WIDTH-bit add. Latency is 1.
- Arithmetic is modulo 2^WIDTH. sum_o wraps; carry_o reports the overflow bit.
- Simultaneous output transfer and input transfer in the same cycle is legal when full, with no bubble inserted.
- Invalid stages may carry stale data. Only valid_o qualifies sum_o and carry_o.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- When defined: extra output ovf_o (1 bit) = signed two's-complement overflow.
  - Computed as carry into the MSB XOR carry out of the MSB, evaluated in the last stage.
  - Reset value 0. Held stable under stall like sum_o.
- When undefined: the port and its logic are absent. The interface is otherwise identical.

Decomposition:
- Package pipe_adder_pkg holds:
  - typedef op_e: OP_ADD=1'b0, OP_SUB=1'b1.
  - function chunk_w(WIDTH, STAGES) returning WIDTH/STAGES.
  - Elaboration check constant/assertion that WIDTH % STAGES == 0.
- One sub-module, adder_slice: combinational, parameter CHUNK, ports a_i, b_i, carry_i, sum_o, carry_o, plus msb_carry_o for the overflow option. Instantiated STAGES times via generate.

Test Plan:
- WIDTH=32, STAGES=4, ready_i=1: add 0x0000_00FF + 0x0000_0001, carry_i=0 -> after 4 cycles sum_o=0x0000_0100, carry_o=0, valid_o high for 1 cycle.
- Cross-slice carry ripple: 0xFFFF_FFFF + 0x0000_0001 -> sum_o=0x0000_0000, carry_o=1. With PIPE_ADDER_OVF_EN, ovf_o=0.
- Subtract: sub_i=1, 5 - 7 -> sum_o=0xFFFF_FFFE, carry_o=0 (borrow). Then 7 - 5 -> sum_o=2, carry_o=1. Signed overflow case 0x8000_0000 - 1 -> sum_o=0x7FFF_FFFF, ovf_o=1.
- Back-to-back stream of 10 random operations, ready_i=1 -> 10 consecutive valid_o cycles, in order, matching the reference model, starting at cycle 4.
- Backpressure: fill the pipeline, then drop ready_i for 3 cycles -> ready_o=0, sum_o/valid_o held constant. Release -> no lost or duplicated results.
- Reset mid-stream: assert rst_i asynchronously with 3 ops in flight -> valid_o=0 and sum_o=0 immediately. No stale results after release; a new op emerges 4 cycles after it is accepted.
